ili9488_frame_sequencer: RTL and testbench
==========================================

// Module: ili9488_frame_sequencer
// PURPOSE
// Sequences the ILI9488 SPI byte driver: runs the panel power-up init command list,
// then on request writes an address window (CASET/PASET/RAMWR) and streams pixel bytes
// from an upstream source. Sits between the convolution output / frame logic and the
// byte-level SPI driver. It is the only master of the driver's Load/in_data/data_cmd inputs.
// PARAMETERS
// DLY_W      24        width of the post-command delay counter
// RST_DLY    600000    clk cycles waited after SWRESET (0x01)
// SLP_DLY    6000000   clk cycles waited after SLPOUT (0x11)
// BPP        3         bytes per pixel (18-bit colour, COLMOD 0x66)
// PORTS
// clk           in   1   system clock, same clock as the SPI driver
// rst           in   1   reset, synchronous, active-high
// init_start    in   1   start panel init sequence (sampled in IDLE)
// win_start     in   1   start window write (sampled in IDLE)
// x0,x1         in   9   column start/end, inclusive, 0..319
// y0,y1         in   9   row start/end, inclusive, 0..479
// pix_data      in   8   pixel byte from upstream
// pix_valid     in   1   pix_data valid
// pix_ready     out  1   byte taken when pix_valid&&pix_ready
// busy          out  1   high whenever state != IDLE
// init_done     out  1   sticky high after init list completes
// frame_done    out  1   one-cycle pulse after last pixel byte finishes
// err           out  1   one-cycle pulse on rejected window
// drv_load      out  1   byte request to driver (Load)
// drv_data      out  8   byte to driver (in_data)
// drv_dc        out  1   0=command, 1=data (data_cmd)
// drv_imd_read  out  1   tied 0 (no readback)
// drv_load_comp in   1   driver accepted byte / shifting
// drv_write_comp in  1   driver idle/write finishing
// BEHAVIOUR
// - Reset (rst=1 at posedge): all outputs 0, state IDLE, counters 0, init_done cleared.
//   rst mid-operation aborts immediately; partially sent byte is abandoned.
// - States: IDLE, SEND, SEND_WAIT, DELAY, PIX_FETCH. Sequence pointer selects next byte.
// - Byte handshake: SEND drives drv_load=1 with drv_data/drv_dc stable until
//   drv_load_comp=1; then SEND_WAIT drives drv_load=0 and waits for drv_load_comp=0 &&
//   drv_write_comp=1 before next byte. drv_data/drv_dc never change while drv_load=1.
// - Init list (init_start in IDLE): 01c,[RST_DLY],11c,[SLP_DLY],3Ac,66d,36c,48d,29c.
//   Delay counted in DELAY from SEND_WAIT exit; exactly N cycles, no byte issued.
//   Completion: init_done<=1, IDLE. init_start during busy ignored.
// - Window (win_start in IDLE with init_done=1): reject if x1<x0, y1<y0, x1>319 or
//   y1>479 -> err pulse, stay IDLE, no drv_load. Else bytes (c=cmd,d=data):
//   2Ac,x0[15:8]d,x0[7:0]d,x1[15:8]d,x1[7:0]d,2Bc,y0 hi/lo d,y1 hi/lo d,2Cc
//   (coordinates zero-extended to 16 bits), then pixel phase.
// - win_start with init_done=0 ignored (no err). init_start and win_start together: init wins.
// - Pixel phase: count = (x1-x0+1)*(y1-y0+1)*BPP, 20-bit, latched at win_start.
//   PIX_FETCH: pix_ready=1; on pix_valid capture byte to drv_data, dc=1, go SEND,
//   decrement count. pix_ready is 0 outside PIX_FETCH. After SEND_WAIT of last byte
//   (count==0): frame_done pulse, IDLE. Upstream gaps simply stall in PIX_FETCH.
// - Latency: first drv_load rises 1 cycle after accepted start; busy rises same edge.
// TESTING
// 1. RST_DLY=4,SLP_DLY=4, driver BFM: init_start -> bytes 01c,11c,3Ac,66d,36c,48d,29c
//    in order; >=4 idle cycles after 01 and 11; init_done=1, busy=0.
// 2. win_start with init_done=0 -> busy stays 0, no drv_load, no err.
// 3. After init, x0=0,x1=1,y0=0,y1=0 -> 2A,00,00,00,01,2B,00,00,00,00,2C (dc pattern
//    c,d,d,d,d,c,d,d,d,d,c) then 6 data bytes equal to pushed pixels; one frame_done.
// 4. Same window, pix_valid toggled with random gaps -> 6 bytes exactly, no duplicates,
//    drv_data stable while drv_load=1.
// 5. x0=5,x1=2 -> err one-cycle pulse, no drv_load, busy=0.
// 6. rst=1 during pixel phase -> next cycle drv_load=0, busy=0, init_done=0, pix_ready=0.

Source files
------------

// File: rtl/ili9488_frame_sequencer.sv
// ILI9488 frame sequencer: panel init list, address window and pixel streaming
// on top of the byte-level SPI driver's Load/in_data/data_cmd handshake.
module ili9488_frame_sequencer #(
   parameter int DLY_W   = 24,
   parameter int RST_DLY = 600000,
   parameter int SLP_DLY = 6000000,
   parameter int BPP     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       init_start,
   input  logic       win_start,
   input  logic [8:0] x0,
   input  logic [8:0] x1,
   input  logic [8:0] y0,
   input  logic [8:0] y1,
   input  logic [7:0] pix_data,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic       busy,
   output logic       init_done,
   output logic       frame_done,
   output logic       err,
   output logic       drv_load,
   output logic [7:0] drv_data,
   output logic       drv_dc,
   output logic       drv_imd_read,
   input  logic       drv_load_comp,
   input  logic       drv_write_comp
);

   localparam logic [8:0] X_MAX     = 9'd319;
   localparam logic [8:0] Y_MAX     = 9'd479;
   localparam logic [3:0] INIT_LAST = 4'd6;
   localparam logic [3:0] WIN_LAST  = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      SEND_WAIT,
      DELAY,
      PIX_FETCH
   } state_t;

   typedef enum logic [1:0] {
      M_INIT,
      M_WIN,
      M_PIX
   } mode_t;

   state_t           state;
   mode_t            mode;
   logic [3:0]       ptr;
   logic [3:0]       nptr;
   logic [DLY_W-1:0] dly_cnt;
   logic [DLY_W-1:0] seq_dly;
   logic [19:0]      pix_cnt;
   logic [8:0]       x0_q;
   logic [8:0]       x1_q;
   logic [8:0]       y0_q;
   logic [8:0]       y1_q;
   logic [7:0]       nxt_byte;
   logic             nxt_dc;
   logic             win_bad;
   logic [19:0]      win_w;
   logic [19:0]      win_h;
   logic [19:0]      win_bytes;
   logic             byte_done;

   assign drv_imd_read = 1'b0;
   assign nptr         = ptr + 4'd1;
   assign byte_done    = !drv_load_comp && drv_write_comp;

   assign win_bad = (x1 < x0) || (y1 < y0) ||
                    (x1 > X_MAX) || (y1 > Y_MAX);
   assign win_w     = 20'(x1) - 20'(x0) + 20'd1;
   assign win_h     = 20'(y1) - 20'(y0) + 20'd1;
   assign win_bytes = win_w * win_h * 20'(BPP);

   // Only SWRESET and SLPOUT carry a settle time after them
   always_comb begin
      seq_dly = '0;
      unique case (1'b1)
         mode == M_INIT && ptr == 4'd0: seq_dly = DLY_W'(RST_DLY);
         mode == M_INIT && ptr == 4'd1: seq_dly = DLY_W'(SLP_DLY);
         default:                       seq_dly = '0;
      endcase
   end

   always_comb begin
      nxt_byte = 8'h00;
      nxt_dc   = 1'b1;
      if (mode == M_INIT) begin
         case (nptr)
            4'd1: begin
               nxt_byte = 8'h11;
               nxt_dc   = 1'b0;
            end
            4'd2: begin
               nxt_byte = 8'h3A;
               nxt_dc   = 1'b0;
            end
            4'd3: nxt_byte = 8'h66;
            4'd4: begin
               nxt_byte = 8'h36;
               nxt_dc   = 1'b0;
            end
            4'd5: nxt_byte = 8'h48;
            4'd6: begin
               nxt_byte = 8'h29;
               nxt_dc   = 1'b0;
            end
            default: begin
               nxt_byte = 8'h01;
               nxt_dc   = 1'b0;
            end
         endcase
      end else begin
         case (nptr)
            4'd1: nxt_byte = {7'd0, x0_q[8]};
            4'd2: nxt_byte = x0_q[7:0];
            4'd3: nxt_byte = {7'd0, x1_q[8]};
            4'd4: nxt_byte = x1_q[7:0];
            4'd5: begin
               nxt_byte = 8'h2B;
               nxt_dc   = 1'b0;
            end
            4'd6: nxt_byte = {7'd0, y0_q[8]};
            4'd7: nxt_byte = y0_q[7:0];
            4'd8: nxt_byte = {7'd0, y1_q[8]};
            4'd9: nxt_byte = y1_q[7:0];
            4'd10: begin
               nxt_byte = 8'h2C;
               nxt_dc   = 1'b0;
            end
            default: begin
               nxt_byte = 8'h2A;
               nxt_dc   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mode       <= M_INIT;
         ptr        <= '0;
         dly_cnt    <= '0;
         pix_cnt    <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         y0_q       <= '0;
         y1_q       <= '0;
         busy       <= 1'b0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         pix_ready  <= 1'b0;
         drv_load   <= 1'b0;
         drv_data   <= 8'h00;
         drv_dc     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (init_start) begin
                  mode     <= M_INIT;
                  ptr      <= '0;
                  drv_data <= 8'h01;
                  drv_dc   <= 1'b0;
                  drv_load <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SEND;
               end else if (win_start && init_done) begin
                  if (win_bad) begin
                     err <= 1'b1;
                  end else begin
                     mode     <= M_WIN;
                     ptr      <= '0;
                     x0_q     <= x0;
                     x1_q     <= x1;
                     y0_q     <= y0;
                     y1_q     <= y1;
                     pix_cnt  <= win_bytes;
                     drv_data <= 8'h2A;
                     drv_dc   <= 1'b0;
                     drv_load <= 1'b1;
                     busy     <= 1'b1;
                     state    <= SEND;
                  end
               end
            end
            SEND: begin
               if (drv_load_comp) begin
                  drv_load <= 1'b0;
                  state    <= SEND_WAIT;
               end
            end
            SEND_WAIT: begin
               if (byte_done) begin
                  case (mode)
                     M_INIT: begin
                        if (ptr == INIT_LAST) begin
                           init_done <= 1'b1;
                           busy      <= 1'b0;
                           state     <= IDLE;
                        end else if (seq_dly != '0) begin
                           dly_cnt <= seq_dly;
                           state   <= DELAY;
                        end else begin
                           drv_data <= nxt_byte;
                           drv_dc   <= nxt_dc;
                           drv_load <= 1'b1;
                           ptr      <= nptr;
                           state    <= SEND;
                        end
                     end
                     M_WIN: begin
                        if (ptr == WIN_LAST) begin
                           mode      <= M_PIX;
                           pix_ready <= 1'b1;
                           state     <= PIX_FETCH;
                        end else begin
                           drv_data <= nxt_byte;
                           drv_dc   <= nxt_dc;
                           drv_load <= 1'b1;
                           ptr      <= nptr;
                           state    <= SEND;
                        end
                     end
                     default: begin
                        if (pix_cnt == '0) begin
                           frame_done <= 1'b1;
                           busy       <= 1'b0;
                           state      <= IDLE;
                        end else begin
                           pix_ready <= 1'b1;
                           state     <= PIX_FETCH;
                        end
                     end
                  endcase
               end
            end
            DELAY: begin
               if (dly_cnt < DLY_W'(2)) begin
                  dly_cnt  <= '0;
                  drv_data <= nxt_byte;
                  drv_dc   <= nxt_dc;
                  drv_load <= 1'b1;
                  ptr      <= nptr;
                  state    <= SEND;
               end else begin
                  dly_cnt <= dly_cnt - DLY_W'(1);
               end
            end
            PIX_FETCH: begin
               if (pix_valid) begin
                  drv_data  <= pix_data;
                  drv_dc    <= 1'b1;
                  drv_load  <= 1'b1;
                  pix_ready <= 1'b0;
                  pix_cnt   <= pix_cnt - 20'd1;
                  state     <= SEND;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ili9488_frame_sequencer.sv
// Randomized bench for ili9488_frame_sequencer: driver BFM, pixel source
// and a byte-list reference model built from the command tables.
module tb_ili9488_frame_sequencer;

   localparam int RD = 4;
   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       init_start;
   logic       win_start;
   logic [8:0] x0;
   logic [8:0] x1;
   logic [8:0] y0;
   logic [8:0] y1;
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       pix_ready;
   logic       busy;
   logic       init_done;
   logic       frame_done;
   logic       err;
   logic       drv_load;
   logic [7:0] drv_data;
   logic       drv_dc;
   logic       drv_imd_read;
   logic       drv_load_comp;
   logic       drv_write_comp;

   int         n_chk = 0;
   int         n_err = 0;
   logic [8:0] got[$];
   int         gap[$];
   logic [8:0] exp_q[$];
   int         idle = 0;
   logic       prev_load = 1'b0;
   logic [8:0] last_b = '0;
   int         fd_n = 0;
   int         err_n = 0;
   logic [7:0] pix_q[$];
   int         pix_idx = 0;
   bit         src_on = 1'b0;
   bit         src_gaps = 1'b0;

   ili9488_frame_sequencer #(
      .DLY_W(24),
      .RST_DLY(RD),
      .SLP_DLY(SD),
      .BPP(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .init_start(init_start),
      .win_start(win_start),
      .x0(x0),
      .x1(x1),
      .y0(y0),
      .y1(y1),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .busy(busy),
      .init_done(init_done),
      .frame_done(frame_done),
      .err(err),
      .drv_load(drv_load),
      .drv_data(drv_data),
      .drv_dc(drv_dc),
      .drv_imd_read(drv_imd_read),
      .drv_load_comp(drv_load_comp),
      .drv_write_comp(drv_write_comp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, want);
      end
   endtask

   task automatic chk_bytes(input string tag);
      logic [31:0] g;
      chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff;
         chk($sformatf("%s_b%0d", tag, i), g, 32'(exp_q[i]));
      end
   endtask

   // Driver BFM: accepts after a random latency, then finishes the shift
   initial begin
      int k;
      int n;
      drv_load_comp  = 1'b0;
      drv_write_comp = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (drv_load === 1'b1) begin
            k = $urandom_range(0, 2);
            repeat (k) begin
               @(posedge clk);
               #2;
            end
            drv_load_comp  = 1'b1;
            drv_write_comp = 1'b0;
            n = 0;
            do begin
               @(posedge clk);
               #2;
               n++;
            end while (drv_load === 1'b1 && n < 64);
            k = $urandom_range(0, 3);
            repeat (k) begin
               @(posedge clk);
               #2;
            end
            drv_load_comp = 1'b0;
            k = $urandom_range(0, 3);
            repeat (k) begin
               @(posedge clk);
               #2;
            end
            drv_write_comp = 1'b1;
         end
      end
   end

   // Pixel source: presents pix_q in order, optionally with random gaps
   initial begin
      bit take;
      take      = 1'b0;
      pix_valid = 1'b0;
      pix_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (take) pix_idx++;
         if (src_on && pix_idx < pix_q.size()) begin
            pix_data  = pix_q[pix_idx];
            pix_valid = src_gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
         end else begin
            pix_valid = 1'b0;
         end
         take = pix_valid && pix_ready && !rst;
      end
   end

   // Byte monitor: records each byte at drv_load rise and the idle gap before it
   always @(negedge clk) begin
      if (rst) begin
         prev_load = 1'b0;
         idle      = 0;
      end else begin
         if (drv_load && prev_load)
            chk("stable", 32'({drv_dc, drv_data}), 32'(last_b));
         if (drv_load && !prev_load) begin
            last_b = {drv_dc, drv_data};
            got.push_back(last_b);
            gap.push_back(idle);
            idle = 0;
         end else if (busy && !drv_load && drv_write_comp && !drv_load_comp) begin
            idle++;
         end
         if (frame_done) fd_n++;
         if (err) err_n++;
         prev_load = drv_load;
      end
   end

   task automatic set_init_exp();
      exp_q = '{9'h001, 9'h011, 9'h03A, 9'h166, 9'h036, 9'h148, 9'h029};
   endtask

   task automatic push_coord(input int v);
      exp_q.push_back({1'b1, 8'(v >> 8)});
      exp_q.push_back({1'b1, 8'(v & 255)});
   endtask

   task automatic pulse_win(input int a0, input int a1,
                            input int b0, input int b1);
      x0 = 9'(a0);
      x1 = 9'(a1);
      y0 = 9'(b0);
      y1 = 9'(b1);
      win_start = 1'b1;
      @(negedge clk);
      win_start = 1'b0;
   endtask

   task automatic run_win(input string tag, input int a0, input int a1,
                          input int b0, input int b1,
                          input bit gaps, input bit poke);
      int np;
      int fd0;
      int n;
      np = (a1 - a0 + 1) * (b1 - b0 + 1) * 3;
      exp_q.delete();
      exp_q.push_back(9'h02A);
      push_coord(a0);
      push_coord(a1);
      exp_q.push_back(9'h02B);
      push_coord(b0);
      push_coord(b1);
      exp_q.push_back(9'h02C);
      pix_q.delete();
      for (int i = 0; i < np; i++) begin
         pix_q.push_back(8'($urandom_range(0, 255)));
         exp_q.push_back({1'b1, pix_q[i]});
      end
      pix_idx  = 0;
      src_gaps = gaps;
      src_on   = 1'b1;
      got.delete();
      fd0 = fd_n;
      pulse_win(a0, a1, b0, b1);
      chk({tag, "_lat_busy"}, 32'(busy), 32'd1);
      chk({tag, "_lat_load"}, 32'(drv_load), 32'd1);
      if (poke) begin
         repeat (3) @(negedge clk);
         init_start = 1'b1;
         @(negedge clk);
         init_start = 1'b0;
      end
      n = 0;
      while (fd_n == fd0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_fd"}, 32'(fd_n - fd0), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_taken"}, 32'(pix_idx), 32'(np));
      chk_bytes(tag);
      src_on = 1'b0;
   endtask

   initial begin
      int n;
      int e0;
      int a;
      int b;
      rst        = 1'b1;
      init_start = 1'b0;
      win_start  = 1'b0;
      x0         = '0;
      x1         = '0;
      y0         = '0;
      y1         = '0;
      repeat (3) @(negedge clk);
      chk("rst_outs", 32'({busy, init_done, frame_done, err, pix_ready,
                           drv_load, drv_data, drv_dc, drv_imd_read}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // window before init is silently ignored
      e0 = err_n;
      pulse_win(0, 1, 0, 0);
      chk("noinit_busy", 32'(busy), 32'd0);
      repeat (8) @(negedge clk);
      chk("noinit_load", 32'(got.size()), 32'd0);
      chk("noinit_err", 32'(err_n - e0), 32'd0);

      // power-up init list
      got.delete();
      gap.delete();
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      chk("init_lat_busy", 32'(busy), 32'd1);
      chk("init_lat_load", 32'(drv_load), 32'd1);
      n = 0;
      while (!init_done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("init_done", 32'(init_done), 32'd1);
      chk("init_busy", 32'(busy), 32'd0);
      set_init_exp();
      chk_bytes("init");
      for (int i = 1; i < 7; i++) begin
         a = (i == 1) ? RD + 1 : (i == 2) ? SD + 1 : 1;
         b = (i < gap.size()) ? gap[i] : -1;
         chk($sformatf("init_gap%0d", i), 32'(b), 32'(a));
      end

      run_win("w2x1", 0, 1, 0, 0, 1'b0, 1'b0);
      run_win("w2x1gap", 0, 1, 0, 0, 1'b1, 1'b1);
      run_win("corner", 319, 319, 479, 479, 1'b1, 1'b0);
      for (int r = 0; r < 3; r++) begin
         int a0;
         int b0;
         a0 = $urandom_range(0, 319);
         b0 = $urandom_range(0, 479);
         a  = (a0 + $urandom_range(0, 2) > 319) ? 319 : a0 + $urandom_range(0, 2);
         b  = (b0 + $urandom_range(0, 1) > 479) ? 479 : b0 + $urandom_range(0, 1);
         run_win($sformatf("rnd%0d", r), a0, a, b0, b, 1'b1, 1'b0);
      end

      // rejected windows: one err pulse, no bytes
      for (int r = 0; r < 4; r++) begin
         got.delete();
         e0 = err_n;
         case (r)
            0: pulse_win(5, 2, 0, 0);
            1: pulse_win(0, 320, 0, 0);
            2: pulse_win(0, 0, 10, 3);
            default: pulse_win(0, 0, 0, 480);
         endcase
         chk($sformatf("rej%0d_err", r), 32'(err), 32'd1);
         chk($sformatf("rej%0d_busy", r), 32'(busy), 32'd0);
         @(negedge clk);
         chk($sformatf("rej%0d_pulse", r), 32'(err), 32'd0);
         repeat (6) @(negedge clk);
         chk($sformatf("rej%0d_n", r), 32'(err_n - e0), 32'd1);
         chk($sformatf("rej%0d_load", r), 32'(got.size()), 32'd0);
      end

      // simultaneous starts: init wins
      got.delete();
      x0 = 9'd0;
      x1 = 9'd1;
      y0 = 9'd0;
      y1 = 9'd0;
      init_start = 1'b1;
      win_start  = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      win_start  = 1'b0;
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      set_init_exp();
      chk_bytes("both");

      // reset during pixel phase
      got.delete();
      src_on = 1'b0;
      pulse_win(0, 1, 0, 0);
      n = 0;
      while (!pix_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_pr", 32'(pix_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_load", 32'(drv_load), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_initd", 32'(init_done), 32'd0);
      chk("mid_pr0", 32'(pix_ready), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
